// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect input and the decode handshake.
// The controller uses the master modport; the memory/decode environment uses slave.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, combinational imem port, 2-entry fetch queue, redirect and fault.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stalled counters.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    fetch_controller_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalled
`endif
);

    typedef enum logic {
        ST_FETCH,
        ST_FAULT
    } state_e;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] ent_instr_q [2];
    logic [31:0] ent_instr_d [2];
    logic [31:0] ent_pc_q    [2];
    logic [31:0] ent_pc_d    [2];

    logic [31:0] pc_word;
    logic        pc_bad;
    logic        deq;
    logic        enq;
    logic [1:0]  slot;

    assign pc_word = {2'b00, pc_q[31:2]};
    assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_word >= MEM_WORDS_W);
    assign deq     = (count_q != 2'd0) && bus.out_ready;
    assign slot    = count_q - 2'(deq);

    assign bus.imem_addr = pc_word;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = ent_instr_q[0];
    assign bus.out_pc    = ent_pc_q[0];
    assign bus.fault     = (state_q == ST_FAULT);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        ent_instr_d = ent_instr_q;
        ent_pc_d    = ent_pc_q;
        enq         = 1'b0;

        if (bus.redirect_valid) begin
            state_d = ST_FETCH;
            pc_d    = bus.redirect_pc;
            count_d = 2'd0;
        end else begin
            if (state_q == ST_FETCH) begin
                if (pc_bad) begin
                    state_d = ST_FAULT;
                end else if ((count_q != 2'd2) || deq) begin
                    enq = 1'b1;
                end
            end

            // Pop shifts entry 1 to the head; the push then lands in the first free slot,
            // which may overwrite the shifted head when the queue held a single entry.
            if (deq) begin
                ent_instr_d[0] = ent_instr_q[1];
                ent_pc_d[0]    = ent_pc_q[1];
            end
            if (enq) begin
                ent_instr_d[slot[0]] = bus.imem_instr;
                ent_pc_d[slot[0]]    = pc_q;
                pc_d                 = pc_q + 32'd4;
            end
            count_d = count_q - 2'(deq) + 2'(enq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            ent_instr_q <= '{default: '0};
            ent_pc_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            ent_instr_q <= ent_instr_d;
            ent_pc_q    <= ent_pc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stalled_q, perf_stalled_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(enq);
        perf_stalled_d = perf_stalled_q + 32'((count_q != 2'd0) && !bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stalled_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stalled_q <= perf_stalled_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios plus randomized traffic
// compared against a queue-based cycle model of the fetch behaviour.
module tb_fetch_controller;
    localparam int unsigned MEM_WORDS = 16384;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fetch_controller_if ifc ();

    logic [31:0] mem [MEM_WORDS];

    assign ifc.imem_instr = (ifc.imem_addr < MEM_WORDS) ? mem[ifc.imem_addr[13:0]] : 32'hBAD0_BAD0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalled;
`endif

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stalled(perf_stalled)
`endif
    );

    // Reference model: a queue of {pc, instr} words updated once per rising edge.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fetched;
    logic [31:0] m_stalled;
    logic        m_deq, m_enq, m_bad;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pc      = 32'h0;
            m_fault   = 1'b0;
            m_fetched = 32'h0;
            m_stalled = 32'h0;
        end else begin
            m_deq = (m_q.size() != 0) && ifc.out_ready;
            if ((m_q.size() != 0) && !ifc.out_ready) m_stalled = m_stalled + 1;
            if (ifc.redirect_valid) begin
                m_q.delete();
                m_pc    = ifc.redirect_pc;
                m_fault = 1'b0;
            end else begin
                m_enq = 1'b0;
                m_bad = ((m_pc % 4) != 0) || ((m_pc / 4) >= MEM_WORDS);
                if (!m_fault) begin
                    if (m_bad) m_fault = 1'b1;
                    else if ((m_q.size() < 2) || m_deq) m_enq = 1'b1;
                end
                if (m_deq) void'(m_q.pop_front());
                if (m_enq) begin
                    m_q.push_back({m_pc, mem[14'(m_pc / 4)]});
                    m_pc      = m_pc + 4;
                    m_fetched = m_fetched + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.out_ready      = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        tick();
        tick();
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", ifc.out_pc); end
        total++; if (ifc.out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", ifc.out_instr); end
        total++; if (ifc.fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", ifc.fault); end
        total++; if (ifc.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ifc.imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, ifc.out_valid); end
            total++; if (ifc.out_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, ifc.out_pc, 32'(4 * i)); end
            total++; if (ifc.out_instr !== 32'(11 * (i + 1))) begin bad++; $display("FAIL stream_instr[%0d] got=%0d exp=%0d", i, ifc.out_instr, 11 * (i + 1)); end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (ifc.imem_addr !== 32'd2) begin bad++; $display("FAIL bp_addr got=%h exp=2", ifc.imem_addr); end
        total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", ifc.out_valid); end
        total++; if ({ifc.out_pc, ifc.out_instr} !== {32'd0, 32'd11}) begin bad++; $display("FAIL bp_head got=%h/%0d exp=0/11", ifc.out_pc, ifc.out_instr); end
        ifc.out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            total++; if ({ifc.out_valid, ifc.out_pc, ifc.out_instr} !== {1'b1, 32'(4 * i), 32'(11 * (i + 1))}) begin
                bad++; $display("FAIL bp_drain[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, ifc.out_valid, ifc.out_pc, ifc.out_instr, 4 * i, 11 * (i + 1));
            end
        end
    endtask

    task automatic test_redirect_full();
        ifc.out_ready      = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h40;
        tick();
        total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b exp=0", ifc.out_valid); end
        total++; if (ifc.imem_addr !== 32'h10) begin bad++; $display("FAIL redir_addr got=%h exp=10", ifc.imem_addr); end
        ifc.redirect_valid = 1'b0;
        ifc.out_ready      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({ifc.out_valid, ifc.out_pc, ifc.out_instr} !== {1'b1, 32'(32'h40 + 4 * i), mem[16 + i]}) begin
                bad++; $display("FAIL redir_stream[%0d] got=%b/%h/%h exp=1/%h/%h", i, ifc.out_valid, ifc.out_pc, ifc.out_instr, 32'h40 + 4 * i, mem[16 + i]);
            end
        end
    endtask

    task automatic test_run_off_end();
        ifc.out_ready      = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFF0;
        tick();
        ifc.redirect_valid = 1'b0;
        tick();
        tick();
        ifc.out_ready = 1'b1;
        tick();
        total++; if (ifc.out_pc !== 32'hFFF4) begin bad++; $display("FAIL end_head1 got=%h exp=FFF4", ifc.out_pc); end
        tick();
        total++; if (ifc.out_pc !== 32'hFFF8 || ifc.fault !== 1'b0) begin bad++; $display("FAIL end_head2 got=%h/%b exp=FFF8/0", ifc.out_pc, ifc.fault); end
        total++; if (ifc.imem_addr !== 32'h4000) begin bad++; $display("FAIL end_addr got=%h exp=4000", ifc.imem_addr); end
        tick();
        total++; if (ifc.fault !== 1'b1) begin bad++; $display("FAIL end_fault got=%b exp=1", ifc.fault); end
        total++; if ({ifc.out_valid, ifc.out_pc, ifc.out_instr} !== {1'b1, 32'hFFFC, mem[16383]}) begin
            bad++; $display("FAIL end_last got=%b/%h/%h exp=1/FFFC/%h", ifc.out_valid, ifc.out_pc, ifc.out_instr, mem[16383]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ifc.out_valid !== 1'b0 || ifc.fault !== 1'b1) begin bad++; $display("FAIL end_quiet[%0d] got=%b/%b exp=0/1", i, ifc.out_valid, ifc.fault); end
        end
    endtask

    task automatic test_fault_redirect();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h2;
        tick();
        total++; if (ifc.fault !== 1'b0) begin bad++; $display("FAIL fr_clear got=%b exp=0", ifc.fault); end
        ifc.redirect_valid = 1'b0;
        tick();
        total++; if (ifc.fault !== 1'b1 || ifc.out_valid !== 1'b0) begin bad++; $display("FAIL fr_misalign got=%b/%b exp=1/0", ifc.fault, ifc.out_valid); end
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h8;
        tick();
        total++; if (ifc.fault !== 1'b0) begin bad++; $display("FAIL fr_recover got=%b exp=0", ifc.fault); end
        ifc.redirect_valid = 1'b0;
        tick();
        total++; if ({ifc.out_valid, ifc.out_pc, ifc.out_instr} !== {1'b1, 32'h8, 32'd33}) begin
            bad++; $display("FAIL fr_resume got=%b/%h/%0d exp=1/8/33", ifc.out_valid, ifc.out_pc, ifc.out_instr);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        ifc.out_ready      = 1'b1;
        ifc.redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ifc.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (perf_stalled !== 32'd4) begin bad++; $display("FAIL perf_stalled got=%0d exp=4", perf_stalled); end
        total++; if (perf_fetched !== 32'd5) begin bad++; $display("FAIL perf_fetched got=%0d exp=5", perf_fetched); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (perf_fetched !== 32'd0 || perf_stalled !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_fetched, perf_stalled); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc, exp_instr;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst                = ($urandom_range(0, 149) == 0);
            ifc.out_ready      = ($urandom_range(0, 9) < 7);
            ifc.redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       ifc.redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
                1:       ifc.redirect_pc = 32'hFFE8 + (32'($urandom_range(0, 5)) << 2);
                2:       ifc.redirect_pc = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
                default: ifc.redirect_pc = ($urandom | 32'h0001_0000) & 32'hFFFF_FFFC;
            endcase
            tick();
            total++; if (ifc.out_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_valid@%0d got=%b exp=%b", cyc, ifc.out_valid, m_q.size() != 0); end
            total++; if (ifc.fault !== m_fault) begin bad++; $display("FAIL rnd_fault@%0d got=%b exp=%b", cyc, ifc.fault, m_fault); end
            total++; if (ifc.imem_addr !== (m_pc >> 2)) begin bad++; $display("FAIL rnd_addr@%0d got=%h exp=%h", cyc, ifc.imem_addr, m_pc >> 2); end
            if (m_q.size() != 0) begin
                {exp_pc, exp_instr} = m_q[0];
                total++; if ({ifc.out_pc, ifc.out_instr} !== {exp_pc, exp_instr}) begin
                    bad++; $display("FAIL rnd_head@%0d got=%h/%h exp=%h/%h", cyc, ifc.out_pc, ifc.out_instr, exp_pc, exp_instr);
                end
            end
`ifdef FETCH_PERF_EN
            total++; if ({perf_fetched, perf_stalled} !== {m_fetched, m_stalled}) begin
                bad++; $display("FAIL rnd_perf@%0d got=%0d/%0d exp=%0d/%0d", cyc, perf_fetched, perf_stalled, m_fetched, m_stalled);
            end
`endif
        end
        rst = 1'b0;
        ifc.redirect_valid = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        ifc.out_ready      = 1'b1;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'd11;
        mem[1] = 32'd22;
        mem[2] = 32'd33;
        mem[3] = 32'd44;
        @(negedge clk);

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_run_off_end();
        test_fault_redirect();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
